// File: rtl/axis_frame_mux_pkg.sv
// ---------------------------------------------------------------------------
// Shared definitions for the AXI4-Stream frame-boundary multiplexer.
//
// vga_pkg : video timing helpers; get_v_res() supplies the active line count
//           of the VGA mode driven by the stream-to-VGA bridge.
// axi_pkg : state encoding for the frame multiplexer FSM.
// ---------------------------------------------------------------------------
package vga_pkg;

  // Active lines per frame of the 800x600 VGA mode.
  function automatic int get_v_res();
    return 600;
  endfunction

endpackage

package axi_pkg;

  // HUNT: waiting for start-of-frame on the active source.
  // PASS: forwarding the active source to the sink.
  typedef enum logic {
    HUNT = 1'b0,
    PASS = 1'b1
  } axis_mux_state_e;

endpackage

// File: rtl/axis_frame_tracker.sv
// ---------------------------------------------------------------------------
// axis_frame_tracker
// Follows the line/frame position of the beats that the multiplexer actually
// forwards, flags the last beat of a frame and detects a start-of-frame that
// arrives somewhere other than the first beat of a frame.
//
// Ports
//   clk, rst   : clock, asynchronous active-high reset
//   beat       : a beat of the active source was accepted this cycle
//   last       : tlast of that beat (end of line)
//   sof        : tuser[0] of that beat (start of frame)
//   frame_end  : combinational, the accepted beat closes the final line
//   sof_err    : registered one-cycle pulse after a misplaced SOF beat
// ---------------------------------------------------------------------------
module axis_frame_tracker #(
  parameter int V_RES = 600
) (
  input  logic clk,
  input  logic rst,
  input  logic beat,
  input  logic last,
  input  logic sof,
  output logic frame_end,
  output logic sof_err
);

  localparam int LW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [LW-1:0] LAST_LINE = LW'(V_RES - 1);

  logic [LW-1:0] line_cnt;
  logic [LW-1:0] base_line;
  logic          mid_line;
  logic          misplaced;

  // Any SOF beat starts a new frame, so the line it belongs to is line 0
  // regardless of where the counter was; an SOF that finds the counter away
  // from the frame start means the previous frame was truncated.
  always_comb begin
    misplaced = beat & sof & ((line_cnt != '0) | mid_line);
    base_line = sof ? '0 : line_cnt;
    frame_end = beat & last & (base_line == LAST_LINE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_cnt <= '0;
      mid_line <= 1'b0;
      sof_err  <= 1'b0;
    end else begin
      sof_err <= misplaced;
      if (beat) begin
        if (last) begin
          mid_line <= 1'b0;
          line_cnt <= frame_end ? '0 : base_line + 1'b1;
        end else begin
          mid_line <= 1'b1;
          line_cnt <= base_line;
        end
      end
    end
  end

endmodule

// File: rtl/axis_frame_mux.sv
// ---------------------------------------------------------------------------
// axis_frame_mux
// Shares one AXI4-Stream video sink between two video sources, switching
// only between complete frames. After a switch the new source is hunted for
// start-of-frame (tuser[0]) before anything is forwarded.
//
// Ports
//   clk_i, rst_i          : AXI clock, asynchronous active-high reset
//   sel_i                 : requested source (0 = s0, 1 = s1)
//   s0_* / s1_*           : source streams (tdata/tuser/tlast/tvalid in,
//                           tready out)
//   m_*                   : stream to the sink (tready in)
//   active_o              : source currently owning the sink
//   pending_o             : switch requested but not yet taken
//   frame_cnt_o           : complete frames forwarded (wraps)
//   sof_err_o             : one-cycle pulse on a misplaced SOF
//
// Configuration macro
//   AXIS_FRAME_MUX_FLUSH_EN : when defined the inactive source is drained
//                             (tready=1, beats discarded) so it free-runs;
//                             otherwise it is held off with tready=0.
// ---------------------------------------------------------------------------
module axis_frame_mux
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int USER_WIDTH = 1,
  parameter int V_RES      = vga_pkg::get_v_res()
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  sel_i,
  input  logic [DATA_WIDTH-1:0] s0_tdata,
  input  logic [USER_WIDTH-1:0] s0_tuser,
  input  logic                  s0_tlast,
  input  logic                  s0_tvalid,
  output logic                  s0_tready,
  input  logic [DATA_WIDTH-1:0] s1_tdata,
  input  logic [USER_WIDTH-1:0] s1_tuser,
  input  logic                  s1_tlast,
  input  logic                  s1_tvalid,
  output logic                  s1_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic [USER_WIDTH-1:0] m_tuser,
  output logic                  m_tlast,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  active_o,
  output logic                  pending_o,
  output logic [15:0]           frame_cnt_o,
  output logic                  sof_err_o
);

  axis_mux_state_e state, state_nxt;
  logic act, act_nxt;

  logic [DATA_WIDTH-1:0] a_tdata;
  logic [USER_WIDTH-1:0] a_tuser;
  logic                  a_tlast;
  logic                  a_tvalid;
  logic                  a_tready;
  logic                  a_sof;
  logic                  inactive_ready;
  logic                  beat;
  logic                  frame_end;
  logic                  sof_err;

`ifdef AXIS_FRAME_MUX_FLUSH_EN
  assign inactive_ready = 1'b1;
`else
  assign inactive_ready = 1'b0;
`endif

  // Active-source view of the two inputs.
  assign a_tdata  = act ? s1_tdata  : s0_tdata;
  assign a_tuser  = act ? s1_tuser  : s0_tuser;
  assign a_tlast  = act ? s1_tlast  : s0_tlast;
  assign a_tvalid = act ? s1_tvalid : s0_tvalid;
  assign a_sof    = a_tuser[0];

  // In HUNT everything but the SOF beat is drained; the SOF beat is left
  // waiting on the source so it becomes the first beat forwarded in PASS.
  // A change of sel_i in HUNT simply retargets the hunt. In PASS a switch
  // is only taken on the beat that closes the frame.
  always_comb begin
    state_nxt = state;
    act_nxt   = act;
    a_tready  = 1'b0;
    case (state)
      HUNT: begin
        a_tready = a_tvalid & ~a_sof;
        if (sel_i != act) begin
          act_nxt = sel_i;
        end else if (a_tvalid & a_sof) begin
          state_nxt = PASS;
        end
      end
      PASS: begin
        a_tready = m_tready;
        if (frame_end && (sel_i != act)) begin
          act_nxt   = sel_i;
          state_nxt = HUNT;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= HUNT;
      act         <= 1'b0;
      frame_cnt_o <= '0;
    end else begin
      state <= state_nxt;
      act   <= act_nxt;
      if (frame_end) begin
        frame_cnt_o <= frame_cnt_o + 16'd1;
      end
    end
  end

  assign s0_tready = act ? inactive_ready : a_tready;
  assign s1_tready = act ? a_tready : inactive_ready;

  assign m_tdata  = a_tdata;
  assign m_tuser  = a_tuser;
  assign m_tlast  = a_tlast;
  assign m_tvalid = (state == PASS) & a_tvalid;

  // Only beats handed to the sink count towards line/frame position.
  assign beat = (state == PASS) & a_tvalid & m_tready;

  axis_frame_tracker #(
    .V_RES(V_RES)
  ) u_tracker (
    .clk      (clk_i),
    .rst      (rst_i),
    .beat     (beat),
    .last     (a_tlast),
    .sof      (a_sof),
    .frame_end(frame_end),
    .sof_err  (sof_err)
  );

  assign active_o  = act;
  assign pending_o = (state == PASS) & (sel_i != act);
  assign sof_err_o = sof_err;

endmodule

// File: tb/tb_axis_frame_mux.sv
// ---------------------------------------------------------------------------
// tb_axis_frame_mux
// Directed bench for axis_frame_mux. Two video sources are modelled as
// position counters (frame, line, pixel) with two beats per line; tdata
// encodes {source, frame[3:0], line[9:0], pixel} so every forwarded beat can
// be predicted from the bench's own bookkeeping.
// ---------------------------------------------------------------------------
module tb_axis_frame_mux;

  localparam int DW          = 16;
  localparam int UW          = 1;
  localparam int VR          = 600;
  localparam int BPL         = 2;
  localparam int FRAME_BEATS = VR * BPL;

`ifdef AXIS_FRAME_MUX_FLUSH_EN
  localparam bit INACT_READY = 1'b1;
`else
  localparam bit INACT_READY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sel = 1'b0;
  logic [DW-1:0] s0_tdata, s1_tdata, m_tdata;
  logic [UW-1:0] s0_tuser, s1_tuser, m_tuser;
  logic          s0_tlast, s1_tlast, m_tlast;
  logic          s0_tvalid, s1_tvalid, m_tvalid;
  logic          s0_tready, s1_tready;
  logic          m_tready = 1'b1;
  logic          active, pending, sof_err;
  logic [15:0]   frame_cnt;

  // Source models: s0 starts mid-frame, s1 starts parked at its SOF.
  int g_line[2]    = '{300, 0};
  int g_pix[2]     = '{1, 0};
  int g_frame[2]   = '{0, 0};
  int inject_at[2] = '{-1, -1};
  bit inj_done[2]  = '{1'b0, 1'b0};
  bit g_en[2]      = '{1'b0, 1'b0};
  bit hs[2];

  logic [DW-1:0] mq_data[$];
  bit            mq_user[$];
  bit            mq_last[$];
  int            sof_pulses = 0;

  int compared = 0;
  int failed   = 0;
  int sw_idx   = 0;

  function automatic logic [15:0] enc(input int src, input int f, input int l, input int p);
    return {src[0], f[3:0], l[9:0], p[0]};
  endfunction

  assign s0_tvalid = g_en[0];
  assign s0_tuser  = (g_line[0] == 0 && g_pix[0] == 0);
  assign s0_tlast  = (g_pix[0] == BPL - 1);
  assign s0_tdata  = enc(0, g_frame[0], g_line[0], g_pix[0]);
  assign s1_tvalid = g_en[1];
  assign s1_tuser  = (g_line[1] == 0 && g_pix[1] == 0);
  assign s1_tlast  = (g_pix[1] == BPL - 1);
  assign s1_tdata  = enc(1, g_frame[1], g_line[1], g_pix[1]);

  axis_frame_mux dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .sel_i      (sel),
    .s0_tdata   (s0_tdata),
    .s0_tuser   (s0_tuser),
    .s0_tlast   (s0_tlast),
    .s0_tvalid  (s0_tvalid),
    .s0_tready  (s0_tready),
    .s1_tdata   (s1_tdata),
    .s1_tuser   (s1_tuser),
    .s1_tlast   (s1_tlast),
    .s1_tvalid  (s1_tvalid),
    .s1_tready  (s1_tready),
    .m_tdata    (m_tdata),
    .m_tuser    (m_tuser),
    .m_tlast    (m_tlast),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .active_o   (active),
    .pending_o  (pending),
    .frame_cnt_o(frame_cnt),
    .sof_err_o  (sof_err)
  );

  always #5 clk = ~clk;

  // Source advance: handshakes are sampled mid-cycle and the source moves to
  // its next beat just after the clock edge that consumed the current one.
  // An armed injection makes the source jump back to line 0 (a new SOF).
  initial begin
    forever begin
      @(negedge clk);
      hs[0] = s0_tvalid & s0_tready;
      hs[1] = s1_tvalid & s1_tready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (hs[i]) begin
          if (g_pix[i] == BPL - 1) begin
            g_pix[i] = 0;
            if (g_line[i] == VR - 1) begin
              g_line[i]  = 0;
              g_frame[i] = g_frame[i] + 1;
            end else begin
              g_line[i] = g_line[i] + 1;
            end
            if (!inj_done[i] && g_line[i] == inject_at[i]) begin
              g_line[i]   = 0;
              inj_done[i] = 1'b1;
            end
          end else begin
            g_pix[i] = g_pix[i] + 1;
          end
        end
      end
    end
  end

  // Sink-side monitor: logs every beat the sink accepts and counts cycles
  // with sof_err_o high.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && m_tvalid && m_tready) begin
        mq_data.push_back(m_tdata);
        mq_user.push_back(m_tuser[0]);
        mq_last.push_back(m_tlast);
      end
      if (sof_err) sof_pulses = sof_pulses + 1;
    end
  end

  // Global safety net so the run always ends.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time exceeded, got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic wait_frame(input int target, input int budget, output bit to);
    to = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk);
      #2;
      if (frame_cnt == 16'(target)) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_line(input int src, input int line, input int pix, input int budget, output bit to);
    to = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk);
      #2;
      if (g_line[src] == line && g_pix[src] == pix) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_qlen(input int n, input int budget, output bit to);
    to = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk);
      #2;
      if (mq_data.size() >= n) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sel = 1'b0;
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    compared++; if (m_tvalid !== 1'b0) begin failed++; $display("[TB] FAIL reset_m_tvalid: got %b expected 0", m_tvalid); end
    compared++; if (s0_tready !== 1'b0) begin failed++; $display("[TB] FAIL reset_s0_tready: got %b expected 0", s0_tready); end
    compared++; if (s1_tready !== INACT_READY) begin failed++; $display("[TB] FAIL reset_s1_tready: got %b expected %b", s1_tready, INACT_READY); end
    compared++; if (active !== 1'b0) begin failed++; $display("[TB] FAIL reset_active: got %b expected 0", active); end
    compared++; if (pending !== 1'b0) begin failed++; $display("[TB] FAIL reset_pending: got %b expected 0", pending); end
    compared++; if (frame_cnt !== 16'd0) begin failed++; $display("[TB] FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
    compared++; if (sof_err !== 1'b0) begin failed++; $display("[TB] FAIL reset_sof_err: got %b expected 0", sof_err); end
  endtask

  task automatic test_first_frame();
    int  base, n, nl, bad;
    bit  to;
    logic [15:0] d;
    g_en[0] = 1'b1;
    g_en[1] = 1'b1;
    base = mq_data.size();
    @(posedge clk);
    #2;
    rst = 1'b0;
    wait_frame(1, 4000, to);
    compared++; if (to) begin failed++; $display("[TB] FAIL first_frame_timeout: frame_cnt %0d expected 1", frame_cnt); end
    n = mq_data.size() - base;
    nl = 0;
    bad = 0;
    for (int k = 0; k < n; k++) begin
      d = mq_data[base + k];
      if (mq_last[base + k]) nl++;
      if (d !== enc(0, 1, k / BPL, k % BPL) || mq_user[base + k] !== (k == 0) || mq_last[base + k] !== (k % BPL == BPL - 1)) bad++;
    end
    compared++; if (n !== FRAME_BEATS) begin failed++; $display("[TB] FAIL first_frame_beats: got %0d expected %0d", n, FRAME_BEATS); end
    compared++; if (nl !== VR) begin failed++; $display("[TB] FAIL first_frame_tlast: got %0d expected %0d", nl, VR); end
    compared++; if (n > 0 && mq_user[base] !== 1'b1) begin failed++; $display("[TB] FAIL first_frame_sof: got %b expected 1", mq_user[base]); end
    compared++; if (bad !== 0) begin failed++; $display("[TB] FAIL first_frame_data: got %0d bad beats expected 0", bad); end
  endtask

  task automatic test_no_switch();
    int fc, base, n;
    bit to;
    fc = frame_cnt;
    base = mq_data.size();
    wait_line(0, 100, 0, 600, to);
    compared++; if (to) begin failed++; $display("[TB] FAIL no_switch_line_timeout: line %0d expected 100", g_line[0]); end
    sel = 1'b1;
    @(posedge clk);
    #2;
    compared++; if (pending !== 1'b1) begin failed++; $display("[TB] FAIL no_switch_pending_on: got %b expected 1", pending); end
    sel = 1'b0;
    @(posedge clk);
    #2;
    compared++; if (pending !== 1'b0) begin failed++; $display("[TB] FAIL no_switch_pending_off: got %b expected 0", pending); end
    wait_frame(fc + 1, 3000, to);
    compared++; if (to) begin failed++; $display("[TB] FAIL no_switch_frame_timeout: frame_cnt %0d expected %0d", frame_cnt, fc + 1); end
    compared++; if (active !== 1'b0) begin failed++; $display("[TB] FAIL no_switch_active: got %b expected 0", active); end
    compared++; if (m_tvalid !== 1'b1) begin failed++; $display("[TB] FAIL no_switch_continuous: m_tvalid got %b expected 1", m_tvalid); end
    n = mq_data.size() - base;
    compared++; if (n !== FRAME_BEATS) begin failed++; $display("[TB] FAIL no_switch_beats: got %0d expected %0d", n, FRAME_BEATS); end
  endtask

  task automatic test_sof_err();
    int fc, base, p0, nl;
    bit to;
    fc = frame_cnt;
    base = mq_data.size();
    p0 = sof_pulses;
    inject_at[0] = 200;
    wait_frame(fc + 1, 4000, to);
    compared++; if (to) begin failed++; $display("[TB] FAIL sof_err_frame_timeout: frame_cnt %0d expected %0d", frame_cnt, fc + 1); end
    nl = 0;
    for (int k = base; k < mq_data.size(); k++) if (mq_last[k]) nl++;
    compared++; if (nl !== 200 + VR) begin failed++; $display("[TB] FAIL sof_err_tlast: got %0d expected %0d", nl, 200 + VR); end
    compared++; if (sof_pulses - p0 !== 1) begin failed++; $display("[TB] FAIL sof_err_pulses: got %0d expected 1", sof_pulses - p0); end
  endtask

  task automatic test_switch();
    int fc, n_before;
    bit to;
    logic [15:0] d;
    fc = frame_cnt;
    wait_line(0, 300, 0, 1000, to);
    compared++; if (to) begin failed++; $display("[TB] FAIL switch_line_timeout: line %0d expected 300", g_line[0]); end
    sel = 1'b1;
    @(posedge clk);
    #2;
    compared++; if (pending !== 1'b1) begin failed++; $display("[TB] FAIL switch_pending_early: got %b expected 1", pending); end
    wait_line(0, VR - 1, 0, 1000, to);
    compared++; if (to || pending !== 1'b1 || active !== 1'b0) begin failed++; $display("[TB] FAIL switch_pending_late: pending %b active %b expected 1 0", pending, active); end
    wait_frame(fc + 1, 200, to);
    compared++; if (to) begin failed++; $display("[TB] FAIL switch_frame_timeout: frame_cnt %0d expected %0d", frame_cnt, fc + 1); end
    compared++; if (active !== 1'b1) begin failed++; $display("[TB] FAIL switch_active: got %b expected 1", active); end
    compared++; if (pending !== 1'b0) begin failed++; $display("[TB] FAIL switch_pending_clear: got %b expected 0", pending); end
    compared++; if (m_tvalid !== 1'b0) begin failed++; $display("[TB] FAIL switch_idle_gap: m_tvalid got %b expected 0", m_tvalid); end
    d = mq_data[mq_data.size() - 1];
    compared++; if ({d[15], d[10:0]} !== {1'b0, 10'd599, 1'b1} || mq_last[mq_data.size() - 1] !== 1'b1) begin failed++; $display("[TB] FAIL switch_last_beat: got %h expected s0 line 599 tlast", d); end
    n_before = mq_data.size();
    wait_qlen(n_before + 1, 3000, to);
    compared++; if (to) begin failed++; $display("[TB] FAIL switch_s1_timeout: queue %0d expected %0d", mq_data.size(), n_before + 1); end
    if (!to) begin
      d = mq_data[n_before];
      compared++; if (d[15] !== 1'b1 || d[10:0] !== 11'd0 || mq_user[n_before] !== 1'b1) begin failed++; $display("[TB] FAIL switch_s1_sof: got data %h user %b expected s1 SOF", d, mq_user[n_before]); end
    end
    sw_idx = n_before;
  endtask

  task automatic test_backpressure();
    int fc, n, bad, f0;
    bit to;
    logic [15:0] d;
    fc = frame_cnt;
    to = 1'b1;
    for (int c = 0; c < 20000; c++) begin
      @(posedge clk);
      #1;
      m_tready = ($urandom_range(0, 3) != 0);
      #1;
      if (frame_cnt == 16'(fc + 3)) begin
        to = 1'b0;
        break;
      end
    end
    m_tready = 1'b1;
    compared++; if (to) begin failed++; $display("[TB] FAIL bp_frame_timeout: frame_cnt %0d expected %0d", frame_cnt, fc + 3); end
    n = mq_data.size() - sw_idx;
    compared++; if (n !== 3 * FRAME_BEATS) begin failed++; $display("[TB] FAIL bp_beats: got %0d expected %0d", n, 3 * FRAME_BEATS); end
    d = mq_data[sw_idx];
    f0 = int'(d[14:11]);
    bad = 0;
    for (int k = 0; k < n; k++) begin
      d = mq_data[sw_idx + k];
      if (d !== enc(1, f0 + k / FRAME_BEATS, (k % FRAME_BEATS) / BPL, k % BPL) ||
          mq_user[sw_idx + k] !== (k % FRAME_BEATS == 0) ||
          mq_last[sw_idx + k] !== (k % BPL == BPL - 1)) bad++;
    end
    compared++; if (bad !== 0) begin failed++; $display("[TB] FAIL bp_scoreboard: got %0d bad beats expected 0", bad); end
  endtask

  task automatic test_reset_mid();
    bit to;
    bit exp_s0;
    to = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #2;
      if (g_pix[1] == 1) begin
        to = 1'b0;
        break;
      end
    end
    compared++; if (to || m_tvalid !== 1'b1) begin failed++; $display("[TB] FAIL rst_mid_precond: m_tvalid %b expected 1 mid-line", m_tvalid); end
    rst = 1'b1;
    sel = 1'b0;
    @(posedge clk);
    #2;
    exp_s0 = g_en[0] && !(g_line[0] == 0 && g_pix[0] == 0);
    compared++; if (m_tvalid !== 1'b0) begin failed++; $display("[TB] FAIL rst_mid_m_tvalid: got %b expected 0", m_tvalid); end
    compared++; if (active !== 1'b0) begin failed++; $display("[TB] FAIL rst_mid_active: got %b expected 0", active); end
    compared++; if (pending !== 1'b0) begin failed++; $display("[TB] FAIL rst_mid_pending: got %b expected 0", pending); end
    compared++; if (frame_cnt !== 16'd0) begin failed++; $display("[TB] FAIL rst_mid_frame_cnt: got %0d expected 0", frame_cnt); end
    compared++; if (sof_err !== 1'b0) begin failed++; $display("[TB] FAIL rst_mid_sof_err: got %b expected 0", sof_err); end
    compared++; if (s1_tready !== INACT_READY) begin failed++; $display("[TB] FAIL rst_mid_s1_tready: got %b expected %b", s1_tready, INACT_READY); end
    compared++; if (s0_tready !== exp_s0) begin failed++; $display("[TB] FAIL rst_mid_s0_tready: got %b expected %b", s0_tready, exp_s0); end
    rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  // Scenario sequence; each scenario continues from where the previous one
  // left the sources and the multiplexer.
  initial begin
    test_reset();
    test_first_frame();
    test_no_switch();
    test_sof_err();
    test_switch();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/axis_frame_mux.md
# axis_frame_mux

Frame-boundary arbiter that shares the single AXI4-Stream video sink (the stream-to-VGA bridge) between two AXI4-Stream video sources, e.g. the test-pattern generator and a future framebuffer reader. It switches sources only between complete frames, so the sink never sees a torn frame. On a switch it hunts for start-of-frame (`tuser[0]`) on the new source. Sits in the AXI clock domain, directly upstream of the bridge.

## Interface
- `DATA_WIDTH`, 16: tdata width (RGB565).
- `USER_WIDTH`, 1: tuser width; bit 0 = start of frame (SOF).
- `V_RES`, 600: lines per frame (`tlast` = end of line).
- `clk_i` input 1: AXI clock; the only clock.
- `rst_i` input 1: asynchronous, active-high reset.
- `sel_i` input 1: requested source (0 = s0, 1 = s1); synchronous to `clk_i` (debounced externally).
- `s0_tdata`/`s0_tuser`/`s0_tlast`/`s0_tvalid` input DATA_WIDTH/USER_WIDTH/1/1: source 0 stream.
- `s0_tready` output 1: source 0 ready.
- `s1_tdata`/`s1_tuser`/`s1_tlast`/`s1_tvalid` input (as s0): source 1 stream.
- `s1_tready` output 1: source 1 ready.
- `m_tdata`/`m_tuser`/`m_tlast`/`m_tvalid` output (as s0): stream to sink.
- `m_tready` input 1: sink ready.
- `active_o` output 1: source currently owning the sink.
- `pending_o` output 1: a switch is requested but not yet taken.
- `frame_cnt_o` output 16: count of complete frames forwarded.
- `sof_err_o` output 1: one-cycle pulse on a misplaced SOF.

## Operation
- The FSM (`HUNT`, `PASS`) owns the "active source" register `act`.
- **HUNT** (entered at reset):
  - If `sel_i != act`, load `act <= sel_i`; hunting restarts on the new source.
  - Active source: `tready = tvalid & ~tuser[0]`, so non-SOF beats are discarded.
  - On `tvalid & tuser[0]`, go to PASS. The SOF beat is held (`tready=0`) and is not consumed in HUNT.
  - `m_tvalid = 0` throughout HUNT.
- **PASS**:
  - Combinational pass-through: `m_* = s_act_*` and `s_act_tready = m_tready`.
  - Beat accepted = `tvalid & tready` on the active source.
  - On an accepted `tlast`, `line_cnt` increments.
  - When an accepted `tlast` arrives with `line_cnt == V_RES-1`, this is frame end:
    - `frame_cnt_o` increments and `line_cnt` clears to 0.
    - If `sel_i != act`, load `act <= sel_i` and go to HUNT; otherwise stay in PASS.
- **SOF check**:
  - An accepted beat with `tuser[0]=1` while `line_cnt != 0` or `mid_line` (a non-tlast beat was accepted since the last tlast) is a misplaced SOF.
  - Response: pulse `sof_err_o`, force `line_cnt=0` and `mid_line` accordingly (the beat starts a new frame), and forward the beat.
  - `frame_cnt_o` does not increment for the truncated frame.
- **Switch request**:
  - `pending_o = (state==PASS) & (sel_i != act)`.
  - If `sel_i` toggles back before frame end, no switch occurs.
- **Inactive source**: behaviour is set by the configuration macro.
- **Widths**:
  - `line_cnt` is `$clog2(V_RES)` bits.
  - `frame_cnt_o` wraps from 0xFFFF to 0.

## Timing
- Reset values:
  - State HUNT, `act=0`, `line_cnt=0`, `mid_line=0`.
  - `frame_cnt_o=0`, `sof_err_o=0`, `pending_o=0`, `active_o=0`.
  - `m_tvalid=0`; both `tready=0` (FLUSH mode: inactive `tready=1`).
- PASS latency: 0 cycles; `m_tvalid` follows `s_act_tvalid` combinationally.
- HUNT→PASS: the SOF beat appears on `m_*` on the cycle after SOF is detected.
- A frame-end beat with a pending switch is forwarded first. The next cycle is in HUNT on the new source, so at least one idle cycle separates the frames.
- Simultaneous frame end and `sel_i` change on the same edge: `sel_i` is sampled on that edge and the switch is taken.
- `m_*` must stay stable while `m_tvalid & ~m_tready`; pass-through inherits the source's AXI stability.
- `rst_i` mid-frame: immediate return to reset values. The sink sees a truncated frame and must resync on the next SOF.

## Configuration
- `AXIS_FRAME_MUX_FLUSH_EN` defined:
  - Inactive source has `tready=1` and its beats are discarded, so the idle generator free-runs.
  - On a switch, hunting starts mid-stream; the first forwarded frame arrives within ≤1 frame time.
- Not defined:
  - Inactive source has `tready=0` (back-pressured, holding its position).
  - The new source is typically already parked at its SOF, so HUNT lasts 1 cycle.

## Structure
- `axi_pkg`: typedef `axis_mux_state_e` {HUNT, PASS}.
- `vga_pkg`: `V_RES` is obtained via `get_v_res()` at the instantiation site; no new constants.
- One sub-module, `axis_frame_tracker`:
  - Contents: `line_cnt`, `mid_line`, frame-end detect and SOF check.
  - Inputs: accepted beat, `tlast`, `tuser[0]`.
  - Outputs: `frame_end`, `sof_err`.
  - One instance, observing the active source's accepted beats.

## Test plan
- Reset with s0 streaming from mid-frame, `sel_i=0` → no `m_tvalid` until s0 SOF; then exactly 600 tlast beats and `frame_cnt_o=1`.
- Toggle `sel_i` 0→1 at line 300 → `pending_o=1` until the 600th tlast; that beat is forwarded from s0, then the next `m_tvalid` beat carries s1 SOF and `active_o=1`.
- Toggle `sel_i` 0→1→0 within one frame → no switch; `frame_cnt_o` increments by 1 and `active_o` stays 0.
- s0 injects SOF at line 200 → one `sof_err_o` pulse, line count restarts, and the next `frame_cnt_o` increment comes 600 lines later.
- Random `m_tready` back-pressure over 3 frames → no beat lost or duplicated; `m_tdata` matches a scoreboard.
- Assert `rst_i` mid-line in PASS → all outputs at reset values next cycle; FLUSH build: inactive `tready=1`, non-FLUSH build: 0.
